tone_waveform_core: RTL and testbench

Phase-accumulator audio oscillator for the FPGA sound path. Produces a 16-bit unsigned waveform sample every clock: sawtooth, variable-width pulse or quarter-wave-LUT sine, selected at run time. The output feeds the mixer/DAC stage. It integrates the saw, pulse and sine-LUT waveform functions behind one registered output.

---
 rtl/tone_waveform_core.sv | 91 +++++++++
 tb/tb_tone_waveform_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tone_waveform_core.sv
// Phase-accumulator oscillator: saw / pulse / quarter-wave sine / silence behind one registered sample.
// Optional build macro AMPLITUDE_SCALE_EN scales every sample by amplitude/256.
module tone_waveform_core #(
  parameter int ACC_W     = 24,
  parameter int LUT_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] tone_freq,
  input  logic [1:0]  waveform_select,
  input  logic [11:0] pulse_width,
  input  logic [7:0]  amplitude,
  output logic [15:0] dout
);

  // Elaboration-time table entry: round(32767*sin(pi*(2k+1)/1024)) via a Q30 Taylor series.
  function automatic logic [14:0] sine_entry(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    x    = (64'sd3373259426 * longint'(2 * k + 1)) / 64'sd1024;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 8; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    scaled = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    return scaled[14:0];
  endfunction

  logic [14:0] sine_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam logic [14:0] ENTRY = sine_entry(k);
    assign sine_rom[k] = ENTRY;
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      dout_q, dout_d;
  logic [15:0]      wave;
  logic [9:0]       phase;
  logic [7:0]       sine_idx;
  logic [14:0]      sine_mag;
  logic [15:0]      sine_val;

  assign acc_d = acc_q + ACC_W'(tone_freq);

  // Odd quadrants read the table backwards; 255-i is just the bitwise inverse of i.
  assign phase    = acc_q[23:14];
  assign sine_idx = phase[8] ? ~phase[7:0] : phase[7:0];
  assign sine_mag = sine_rom[sine_idx];
  assign sine_val = phase[9] ? (16'd32767 - {1'b0, sine_mag})
                             : (16'd32768 + {1'b0, sine_mag});

  always_comb begin
    wave = 16'h8000;
    case (waveform_select)
      2'd0:    wave = acc_q[23:8];
      2'd1:    wave = (acc_q[23:12] <= pulse_width) ? 16'hFFFF : 16'h0000;
      2'd2:    wave = sine_val;
      default: wave = 16'h8000;
    endcase
  end

`ifdef AMPLITUDE_SCALE_EN
  logic [23:0] scaled_prod;
  assign scaled_prod = {8'h00, wave} * {16'h0000, amplitude};
  assign dout_d      = scaled_prod[23:8];
`else
  logic unused_amplitude;
  assign unused_amplitude = ^amplitude;
  assign dout_d           = wave;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      dout_q <= 16'h0000;
    end else begin
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_tone_waveform_core.sv
// Directed bench for tone_waveform_core; expected samples are hand-derived constants.
module tb_tone_waveform_core;

  logic        clk;
  logic        rst;
  logic [15:0] tone_freq;
  logic [1:0]  waveform_select;
  logic [11:0] pulse_width;
  logic [7:0]  amplitude;
  logic [15:0] dout;

  int n_cmp;
  int n_bad;

  tone_waveform_core dut (
    .clk             (clk),
    .rst             (rst),
    .tone_freq       (tone_freq),
    .waveform_select (waveform_select),
    .pulse_width     (pulse_width),
    .amplitude       (amplitude),
    .dout            (dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Expected output for a raw waveform value given the current amplitude setting.
  function automatic logic [15:0] scale(input logic [15:0] w);
`ifdef AMPLITUDE_SCALE_EN
    logic [23:0] p;
    p = {8'h00, w} * {16'h0000, amplitude};
    return p[23:8];
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic [15:0] f, input logic [1:0] sel, input logic [11:0] pw);
    @(posedge clk);
    #2;
    rst             = 1'b1;
    tone_freq       = f;
    waveform_select = sel;
    pulse_width     = pw;
    step();
    rst = 1'b0;
  endtask

  int highs;
  int first_low;

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    rst             = 1'b1;
    tone_freq       = 16'h0100;
    waveform_select = 2'd0;
    pulse_width     = 12'h000;
    amplitude       = 8'h80;
    #3;
    check_eq("reset_dout", dout, 16'h0000);

    // Saw from reset: first edge shows wave(0), then +1 per edge.
    step();
    rst = 1'b0;
    step(); check_eq("saw_e1", dout, scale(16'h0000));
    step(); check_eq("saw_e2", dout, scale(16'h0001));
    step(); check_eq("saw_e3", dout, scale(16'h0002));
    step(); check_eq("saw_e4", dout, scale(16'h0003));

    // Asynchronous reset mid-run, observed before any clock edge.
    rst = 1'b1;
    #1;
    check_eq("async_rst", dout, 16'h0000);

    // Drive acc to 0xFFFF00 quickly, then watch the saw wrap.
    do_reset(16'hFFFF, 2'd0, 12'h000);
    steps(256);
    tone_freq = 16'h0100;
    step(); check_eq("wrap_top", dout, scale(16'hFFFF));
    step(); check_eq("wrap_zero", dout, scale(16'h0000));
    step(); check_eq("wrap_one", dout, scale(16'h0001));

    waveform_select = 2'd3;
    step(); check_eq("silence", dout, scale(16'h8000));

    // Pulse duty over one full 4096-cycle period.
    do_reset(16'h1000, 2'd1, 12'h800);
    highs     = 0;
    first_low = -1;
    for (int i = 0; i < 4096; i++) begin
      step();
      if (dout == scale(16'hFFFF)) highs++;
      else if (first_low < 0) first_low = i;
    end
    check_eq("pulse_highs", 16'(highs), 16'h0801);
    check_eq("pulse_run", 16'(first_low), 16'h0801);

    pulse_width = 12'hFFF;
    steps(2);
    check_eq("pulse_full_a", dout, scale(16'hFFFF));
    steps(1000);
    check_eq("pulse_full_b", dout, scale(16'hFFFF));

    // Sine held at phase 0, then stepped to the quadrant boundaries.
    do_reset(16'h0000, 2'd2, 12'h000);
    step(); check_eq("sine_frz_a", dout, scale(16'h8065));
    steps(5); check_eq("sine_frz_b", dout, scale(16'h8065));

    tone_freq = 16'h4000; steps(256); tone_freq = 16'h0000;
    step(); check_eq("sine_q1", dout, scale(16'hFFFF));
    tone_freq = 16'h4000; steps(256); tone_freq = 16'h0000;
    step(); check_eq("sine_q2", dout, scale(16'h7F9A));
    tone_freq = 16'h4000; steps(256); tone_freq = 16'h0000;
    step(); check_eq("sine_q3", dout, scale(16'h0000));
    steps(3); check_eq("sine_q3_hold", dout, scale(16'h0000));

    // Amplitude behaviour on silence and full-scale saw.
    waveform_select = 2'd3;
    amplitude       = 8'h80;
    step();
`ifdef AMPLITUDE_SCALE_EN
    check_eq("amp_silence", dout, 16'h4000);
`else
    check_eq("amp_ignored", dout, 16'h8000);
`endif
    do_reset(16'hFFFF, 2'd0, 12'h000);
    amplitude = 8'h00;
    steps(256);
    tone_freq = 16'h0000;
    step();
`ifdef AMPLITUDE_SCALE_EN
    check_eq("amp_zero", dout, 16'h0000);
`else
    check_eq("saw_top_noamp", dout, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
